// File: rtl/image_filter_stream.sv
// Streaming 3x3 grayscale filter: RGB to gray, two line buffers, run-time kernel select,
// two-stage pipeline (window/partial sums, then kernel result) with valid/ready on both sides.
module image_filter_stream #(
    parameter int BIT_PER_PIXEL = 8,
    parameter int IMG_WIDTH     = 640,
    parameter int IMG_HEIGHT    = 480
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sof,
    input  logic [BIT_PER_PIXEL-1:0] in_red,
    input  logic [BIT_PER_PIXEL-1:0] in_green,
    input  logic [BIT_PER_PIXEL-1:0] in_blue,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_eof,
    output logic [BIT_PER_PIXEL-1:0] filter_out
);
    localparam int W  = BIT_PER_PIXEL;
    localparam int SW = W + 5;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [W-1:0]  PIX_MAX  = '1;

    function automatic logic [W+1:0] wsum3(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    function automatic logic signed [SW-1:0] abs_s(input logic signed [SW-1:0] v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [W-1:0] sat_u(input logic signed [SW-1:0] v);
        if (v < 0) return '0;
        if (v > $signed({{(SW-W){1'b0}}, PIX_MAX})) return PIX_MAX;
        return W'(v);
    endfunction

    logic            stall, accept, take, win_ok, is_last;
    logic [W-1:0]    gray, lb1_rd, lb2_rd;
    logic [CW-1:0]   col_q, col_d, cur_col;
    logic [RW-1:0]   row_q, row_d, cur_row;
    logic            frame_active_q, frame_active_d;
    logic [1:0]      mode_q, mode_d;
    logic [W-1:0]    lb1_mem [IMG_WIDTH];
    logic [W-1:0]    lb2_mem [IMG_WIDTH];
    logic [W-1:0]    t1_q, t1_d, t2_q, t2_d, m1_q, m1_d, m2_q, m2_d, b1_q, b1_d, b2_q, b2_d;
    logic [W-1:0]    p0, p1, p2, p3, p4, p5, p6, p7, p8;
    logic            vld_p1_q, vld_p1_d, eof_p1_q, eof_p1_d;
    logic [1:0]      mode_p1_q, mode_p1_d;
    logic [W-1:0]    p4_p1_q, p4_p1_d;
    logic [W+1:0]    row_t_p1_q, row_t_p1_d, row_m_p1_q, row_m_p1_d, row_b_p1_q, row_b_p1_d;
    logic [W+1:0]    col_l_p1_q, col_l_p1_d, col_r_p1_q, col_r_p1_d, cross_p1_q, cross_p1_d;
    logic signed [SW-1:0] gx, gy, lap;
    logic [W-1:0]    kern;
    logic            out_valid_q, out_valid_d, out_eof_q, out_eof_d;
    logic [W-1:0]    filter_out_q, filter_out_d;

    assign stall      = out_valid_q && !out_ready;
    assign in_ready   = !stall;
    assign accept     = in_valid && in_ready;
    assign out_valid  = out_valid_q;
    assign out_eof    = out_eof_q;
    assign filter_out = filter_out_q;
    assign gray   = W'(({2'b00, in_red} + {1'b0, in_green, 1'b0} + {2'b00, in_blue}) >> 2);
    assign lb1_rd = lb1_mem[cur_col];
    assign lb2_rd = lb2_mem[cur_col];

    // Window: line buffers give the column above, tap registers hold the two prior columns
    assign p0 = t2_q;  assign p1 = t1_q;  assign p2 = lb2_rd;
    assign p3 = m2_q;  assign p4 = m1_q;  assign p5 = lb1_rd;
    assign p6 = b2_q;  assign p7 = b1_q;  assign p8 = gray;

    always_comb begin
        cur_col = in_sof ? '0 : col_q;
        cur_row = in_sof ? '0 : row_q;
        take    = accept && (in_sof || frame_active_q);
        win_ok  = take && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        is_last = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        col_d          = col_q;
        row_d          = row_q;
        frame_active_d = frame_active_q;
        mode_d         = mode_q;
        if (take) begin
            if (in_sof) mode_d = mode;
            frame_active_d = 1'b1;
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
                if (cur_row == ROW_LAST) frame_active_d = 1'b0;
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    always_comb begin
        t1_d = t1_q;  t2_d = t2_q;
        m1_d = m1_q;  m2_d = m2_q;
        b1_d = b1_q;  b2_d = b2_q;
        if (take) begin
            t2_d = t1_q;  t1_d = lb2_rd;
            m2_d = m1_q;  m1_d = lb1_rd;
            b2_d = b1_q;  b1_d = gray;
        end
    end

    // Stage 1: window reduced to row/column/cross partial sums
    always_comb begin
        vld_p1_d   = stall ? vld_p1_q : win_ok;
        eof_p1_d   = stall ? eof_p1_q : (win_ok && is_last);
        mode_p1_d  = mode_p1_q;
        p4_p1_d    = p4_p1_q;
        row_t_p1_d = row_t_p1_q;
        row_m_p1_d = row_m_p1_q;
        row_b_p1_d = row_b_p1_q;
        col_l_p1_d = col_l_p1_q;
        col_r_p1_d = col_r_p1_q;
        cross_p1_d = cross_p1_q;
        if (win_ok) begin
            mode_p1_d  = mode_q;
            p4_p1_d    = p4;
            row_t_p1_d = wsum3(p0, p1, p2);
            row_m_p1_d = wsum3(p3, p4, p5);
            row_b_p1_d = wsum3(p6, p7, p8);
            col_l_p1_d = wsum3(p0, p3, p6);
            col_r_p1_d = wsum3(p2, p5, p8);
            cross_p1_d = {2'b00, p1} + {2'b00, p3} + {2'b00, p5} + {2'b00, p7};
        end
    end

    // Stage 2: kernel result
    always_comb begin
        gx  = $signed({3'b000, col_r_p1_q}) - $signed({3'b000, col_l_p1_q});
        gy  = $signed({3'b000, row_b_p1_q}) - $signed({3'b000, row_t_p1_q});
        lap = $signed({3'b000, p4_p1_q, 2'b00}) - $signed({3'b000, cross_p1_q});
        case (mode_p1_q)
            2'd0:    kern = p4_p1_q;
            2'd1:    kern = W'(({2'b00, row_t_p1_q} + {1'b0, row_m_p1_q, 1'b0}
                               + {2'b00, row_b_p1_q}) >> 4);
            2'd2:    kern = sat_u(abs_s(gx) + abs_s(gy));
            default: kern = sat_u(abs_s(lap));
        endcase
        out_valid_d  = stall ? out_valid_q : vld_p1_q;
        out_eof_d    = stall ? out_eof_q : (vld_p1_q && eof_p1_q);
        filter_out_d = (!stall && vld_p1_q) ? kern : filter_out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q          <= '0;
            row_q          <= '0;
            frame_active_q <= 1'b0;
            mode_q         <= '0;
            vld_p1_q       <= 1'b0;
            eof_p1_q       <= 1'b0;
            out_valid_q    <= 1'b0;
            out_eof_q      <= 1'b0;
            filter_out_q   <= '0;
        end else begin
            col_q          <= col_d;
            row_q          <= row_d;
            frame_active_q <= frame_active_d;
            mode_q         <= mode_d;
            vld_p1_q       <= vld_p1_d;
            eof_p1_q       <= eof_p1_d;
            out_valid_q    <= out_valid_d;
            out_eof_q      <= out_eof_d;
            filter_out_q   <= filter_out_d;
        end
    end

    always_ff @(posedge clk) begin
        t1_q       <= t1_d;
        t2_q       <= t2_d;
        m1_q       <= m1_d;
        m2_q       <= m2_d;
        b1_q       <= b1_d;
        b2_q       <= b2_d;
        mode_p1_q  <= mode_p1_d;
        p4_p1_q    <= p4_p1_d;
        row_t_p1_q <= row_t_p1_d;
        row_m_p1_q <= row_m_p1_d;
        row_b_p1_q <= row_b_p1_d;
        col_l_p1_q <= col_l_p1_d;
        col_r_p1_q <= col_r_p1_d;
        cross_p1_q <= cross_p1_d;
        if (take) begin
            lb1_mem[cur_col] <= gray;
            lb2_mem[cur_col] <= lb1_rd;
        end
    end

endmodule

// File: tb/tb_image_filter_stream.sv
// Self-checking bench for image_filter_stream on a 4x4 frame: hand-computed vector table,
// corner-case sequences, and randomized frames against an image-level reference model.
module tb_image_filter_stream;
    localparam int BPP = 8;
    localparam int IW  = 4;
    localparam int IH  = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1:0]     mode = 2'd0;
    logic           in_valid = 1'b0;
    logic           in_sof = 1'b0;
    logic [BPP-1:0] in_red = '0, in_green = '0, in_blue = '0;
    logic           in_ready, out_valid, out_eof;
    logic           out_ready = 1'b1;
    logic [BPP-1:0] filter_out;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;   // 0 always ready, 1 random, 2 repeating 1,0,0,1, 3 never ready
    int rdy_step = 0;
    bit mon_en = 1'b0;
    bit proto_en = 1'b0;
    logic [BPP:0] got_q[$];
    logic [BPP:0] exp_q[$];
    int img_r[IH][IW];
    int img_g[IH][IW];
    int img_b[IH][IW];

    typedef struct packed {
        logic [1:0]       md;
        logic [3:0]       pat;
        logic [3:0][7:0]  e;
    } vec_t;
    vec_t tbl[6];

    image_filter_stream #(.BIT_PER_PIXEL(BPP), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .out_valid(out_valid), .out_ready(out_ready), .out_eof(out_eof),
        .filter_out(filter_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            2: begin
                out_ready = (rdy_step % 4 == 0) || (rdy_step % 4 == 3);
                rdy_step++;
            end
            default: out_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    logic           prev_stall = 1'b0;
    logic [BPP-1:0] prev_f = '0;
    logic           prev_e = 1'b0;
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (proto_en) begin
                chk("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
                if (prev_stall) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_data", 32'(filter_out), 32'(prev_f));
                    chk("hold_eof", 32'(out_eof), 32'(prev_e));
                end
            end
            if (out_valid && out_ready) got_q.push_back({out_eof, filter_out});
            prev_stall = out_valid && !out_ready;
            prev_f     = filter_out;
            prev_e     = out_eof;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic fill_pattern(input int pat);
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                int v;
                case (pat)
                    0: v = 100;
                    1: v = (c >= 2) ? 200 : 0;
                    2: v = 10 * (r * IW + c) + 5;
                    default: v = 0;
                endcase
                img_r[r][c] = v;
                img_g[r][c] = v;
                img_b[r][c] = v;
            end
        end
        if (pat == 3) begin
            img_r[1][1] = 255; img_g[1][1] = 0;   img_b[1][1] = 1;
            img_r[1][2] = 255; img_g[1][2] = 255; img_b[1][2] = 255;
        end
        if (pat == 4) begin
            img_r[1][1] = 255; img_g[1][1] = 255; img_b[1][1] = 255;
        end
    endtask

    task automatic fill_random();
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                img_r[r][c] = int'($urandom_range(0, 255));
                img_g[r][c] = int'($urandom_range(0, 255));
                img_b[r][c] = int'($urandom_range(0, 255));
            end
        end
    endtask

    function automatic int gray_of(input int r, input int c);
        return (img_r[r][c] + 2 * img_g[r][c] + img_b[r][c]) / 4;
    endfunction

    // Reference: every interior pixel of the stored image, row-major, kernel applied directly
    task automatic build_expected(input int md);
        exp_q.delete();
        for (int r = 2; r < IH; r++) begin
            for (int c = 2; c < IW; c++) begin
                int p[9];
                int v, gx, gy;
                for (int k = 0; k < 9; k++) p[k] = gray_of(r - 2 + k / 3, c - 2 + k % 3);
                case (md)
                    0: v = p[4];
                    1: v = (p[0] + 2*p[1] + p[2] + 2*p[3] + 4*p[4] + 2*p[5]
                            + p[6] + 2*p[7] + p[8]) / 16;
                    2: begin
                        gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
                        gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
                        v = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                        if (v > 255) v = 255;
                    end
                    default: begin
                        v = 4*p[4] - p[1] - p[3] - p[5] - p[7];
                        if (v < 0) v = -v;
                        if (v > 255) v = 255;
                    end
                endcase
                exp_q.push_back({1'(r == IH-1 && c == IW-1), 8'(v)});
            end
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the pixel.
    // Non-sof pixels carry a different mode so that only the sof value may take effect.
    task automatic push_px(input int r, input int c, input bit sof, input int md);
        int waited = 0;
        in_valid = 1'b1;
        in_sof   = sof;
        mode     = sof ? 2'(md) : 2'(md ^ 3);
        in_red   = 8'(img_r[r][c]);
        in_green = 8'(img_g[r][c]);
        in_blue  = 8'(img_b[r][c]);
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            waited++;
            if (waited > 200) begin
                chk("push_timeout", 32'(waited), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int md, input bit gaps);
        for (int i = 0; i < IW * IH; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            push_px(i / IW, i % IW, i == 0, md);
        end
    endtask

    task automatic finish_frame(input string tag);
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (8) @(posedge clk);
        #1;
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_px%0d", tag, i), 32'(got_q[i][7:0]), 32'(exp_q[i][7:0]));
            chk($sformatf("%s_eof%0d", tag, i), 32'(got_q[i][8]), 32'(exp_q[i][8]));
        end
        got_q.delete();
    endtask

    task automatic set_vec(input int i, input int md, input int pat,
                           input int a, input int b, input int c, input int d);
        tbl[i].md   = 2'(md);
        tbl[i].pat  = 4'(pat);
        tbl[i].e[0] = 8'(a);
        tbl[i].e[1] = 8'(b);
        tbl[i].e[2] = 8'(c);
        tbl[i].e[3] = 8'(d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        set_vec(0, 1, 0, 100, 100, 100, 100);
        set_vec(1, 2, 1, 255, 255, 255, 255);
        set_vec(2, 0, 1, 0, 200, 0, 200);
        set_vec(3, 0, 3, 64, 255, 0, 0);
        set_vec(4, 3, 4, 255, 255, 255, 0);
        set_vec(5, 1, 3, 47, 71, 23, 35);

        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_eof", 32'(out_eof), 32'd0);
        chk("rst_filter_out", 32'(filter_out), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Latency: first window is the 11th pixel, out_valid two edges after its acceptance
        fill_pattern(0);
        build_expected(1);
        for (int i = 0; i < IW * IH; i++) begin
            push_px(i / IW, i % IW, i == 0, 1);
            if (i == 10) chk("lat_before", 32'(out_valid), 32'd0);
            if (i == 11) begin
                chk("lat_valid", 32'(out_valid), 32'd1);
                chk("lat_data", 32'(filter_out), 32'd100);
            end
        end
        finish_frame("lat");

        for (int i = 0; i < 6; i++) begin
            fill_pattern(int'(tbl[i].pat));
            exp_q.delete();
            for (int k = 0; k < 4; k++) exp_q.push_back({1'(k == 3), tbl[i].e[k]});
            send_frame(int'(tbl[i].md), 1'b0);
            finish_frame($sformatf("vec%0d", i));
        end

        // Backpressure with out_ready 1,0,0,1
        rdy_step = 0;
        rdy_mode = 2;
        proto_en = 1'b1;
        fill_pattern(2);
        build_expected(0);
        send_frame(0, 1'b0);
        finish_frame("bp");
        rdy_mode = 0;

        // Restart via sof at row 2 col 1, mode 0 -> 3
        fill_pattern(2);
        for (int i = 0; i < 9; i++) push_px(i / IW, i % IW, i == 0, 0);
        fill_pattern(4);
        build_expected(3);
        send_frame(3, 1'b0);
        finish_frame("sof_restart");

        // Asynchronous reset while an output is held
        fill_pattern(2);
        for (int i = 0; i < 11; i++) push_px(i / IW, i % IW, i == 0, 0);
        rdy_mode = 3;
        @(posedge clk);
        #2;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_eof", 32'(out_eof), 32'd0);
        chk("arst_filter_out", 32'(filter_out), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        got_q.delete();
        for (int i = 0; i < IW * IH; i++) push_px(i / IW, i % IW, 1'b0, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("nosof_dropped", 32'(got_q.size()), 32'd0);
        fill_pattern(1);
        build_expected(0);
        send_frame(0, 1'b0);
        for (int i = 0; i < 6; i++) push_px(i / IW, i % IW, 1'b0, 0);
        finish_frame("post_rst");

        // Randomized frames, random modes, gaps and out_ready
        rdy_mode = 1;
        for (int f = 0; f < 8; f++) begin
            int md;
            md = int'($urandom_range(0, 3));
            fill_random();
            build_expected(md);
            send_frame(md, 1'b1);
            finish_frame($sformatf("rand%0d_m%0d", f, md));
        end
        rdy_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/image_filter_stream.md
Name: image_filter_stream

Overview:
Streaming 3x3 spatial filter for RGB video. Converts each accepted RGB pixel to grayscale and stores two previous rows in internal line buffers. Applies a run-time selectable 3x3 kernel (pass, smooth, Sobel, Laplacian). Uses valid/ready handshakes on both sides and sits between the camera capture path and the frame writer.

Parameters:
BIT_PER_PIXEL, 8, width of each colour channel and of the filtered output
IMG_WIDTH, 640, pixels per row (>=3); sets line-buffer depth
IMG_HEIGHT, 480, rows per frame (>=3)

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
mode  input  2  kernel select; sampled when the in_sof pixel is accepted
in_valid  input  1  input pixel valid
in_ready  output  1  block can accept a pixel
in_sof  input  1  first pixel of a frame, qualified by in_valid
in_red  input  BIT_PER_PIXEL  red channel
in_green  input  BIT_PER_PIXEL  green channel
in_blue  input  BIT_PER_PIXEL  blue channel
out_valid  output  1  filter_out valid
out_ready  input  1  downstream accepts filter_out
out_eof  output  1  marks the last output pixel of a frame
filter_out  output  BIT_PER_PIXEL  filtered grayscale pixel

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_eof=0, filter_out=0, in_ready=1, counters=0, active mode=0, frame_active=0. Line-buffer contents are don't-care.
- Accept: transfer occurs when in_valid && in_ready. in_ready = !(out_valid && !out_ready). The whole pipeline stalls while out_valid && !out_ready; filter_out, out_eof and the window must hold stable.
- Grayscale: g = (R + 2G + B) >> 2, computed at full precision (BIT_PER_PIXEL+2 bits), result BIT_PER_PIXEL bits.
- Counters: col 0..IMG_WIDTH-1 and row 0..IMG_HEIGHT-1.
  - Accepting a pixel with in_sof=1 forces col=0, row=0 for that pixel, sets frame_active=1 and latches mode. This applies even mid-frame; no further outputs are produced for the old frame.
  - After the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1), frame_active=0. Further pixels are accepted and dropped with no output until the next in_sof. Pixels received before any in_sof are also dropped.
- Window: p0..p8 row-major; p0 is the top-left pixel and p8 is the current input. The window is valid when the input pixel has row>=2 and col>=2, giving (IMG_WIDTH-2)*(IMG_HEIGHT-2) outputs per frame. Border pixels are never emitted.
- Kernels (signed intermediate, wide enough that nothing overflows):
  - mode 0: out = p4.
  - mode 1: out = (p0+2p1+p2+2p3+4p4+2p5+p6+2p7+p8) >> 4, truncated.
  - mode 2: Gx = (p2+2p5+p8)-(p0+2p3+p6); Gy = (p6+2p7+p8)-(p0+2p1+p2); out = min(|Gx|+|Gy|, 2^BIT_PER_PIXEL-1).
  - mode 3: out = min(|4p4-p1-p3-p5-p7|, 2^BIT_PER_PIXEL-1).
- Pipeline and latency: stage 1 registers the window and partial sums; stage 2 registers filter_out. out_valid rises 2 cycles after the accepting edge when there is no stall.
- out_eof=1 with the output whose window input is (IMG_HEIGHT-1, IMG_WIDTH-1).
- Simultaneous events: out_ready high in the same cycle that out_valid is held allows a new accept in that same cycle (no bubble).
- Reset asserted mid-frame: everything cleared immediately; the next frame needs in_sof.

Test Plan:
1. W=4, H=4, mode 1, all pixels R=G=B=100 with sof on the first, out_ready=1 -> exactly 4 outputs of 100; out_eof on the 4th only; first out_valid 2 cycles after the 11th accepted pixel.
2. W=4, H=4, mode 2, columns 0-1 = 0 and columns 2-3 = 200 -> 4 outputs, each min(800,255)=255. The same frame in mode 0 -> outputs 0, 200, 0, 200.
3. Grayscale check, mode 0: R=255, G=0, B=1 gives g=64 at the centre; R=G=B=255 gives 255 with no overflow. Laplacian with centre 255 and neighbours 0 -> 255 (saturated).
4. Backpressure: out_ready toggles 1,0,0,1 during frame 1 -> in_ready low exactly while out_valid && !out_ready. filter_out stable while stalled; no outputs lost or duplicated (4 total).
5. in_sof asserted at row 2 col 1 of a frame -> counters restart; mode relatched (0 to 3 takes effect); the next outputs follow the new frame's row 2.
6. rst_n pulsed low asynchronously mid-cycle during frame 1 -> out_valid=0 and in_ready=1 immediately. Pixels without sof are dropped; a following full frame produces the correct 4 outputs.
